// File: rtl/dsp_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mem_arbiter_pkg
// Purpose  : Shared constants for the DSP data-memory arbiter: memory address
//            and data word widths, requester IDs and bank-select values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dsp_mem_arbiter_pkg;

  // Full memory address width (MSB selects the bank) and data word width.
  localparam int C_MEM_ADDR_LEN = 8;
  localparam int C_REG_WORD_LEN = 16;

  // Requester IDs; also the bit positions inside per-bank req/gnt vectors.
  localparam logic C_ARB_CORE = 1'b0;
  localparam logic C_ARB_SAMP = 1'b1;

  // Bank-select values carried in the address MSB.
  localparam logic C_BANK1 = 1'b0;
  localparam logic C_BANK2 = 1'b1;

endpackage : dsp_mem_arbiter_pkg
`default_nettype wire

// File: rtl/dsp_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mem_rr_arb2
// Purpose  : Two-way round-robin arbiter for one memory bank. The pointer
//            names the favoured requester on a contested cycle and then moves
//            to that cycle's loser.
// Ports    : clk       - system clock
//            rst       - asynchronous active-high reset
//            req[1:0]  - requests, bit 0 = core, bit 1 = sample port
//            gnt[1:0]  - one-hot (or zero) grants, same bit order as req
//            contested - both requesters target this bank this cycle
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mem_rr_arb2
  import dsp_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       contested
);

  logic r_ptr;

  always_comb begin
    gnt       = 2'b00;
    contested = 1'b0;
    if (!rst) begin
      contested = req[C_ARB_CORE] & req[C_ARB_SAMP];
      if (contested) begin
        gnt[r_ptr] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  // Winner was r_ptr, so inverting it points at the loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= C_ARB_CORE;
    end else if (contested) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule : dsp_mem_rr_arb2
`default_nettype wire

// File: rtl/dsp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mem_arbiter
// Purpose  : Two-requester (core, sample-ingest), two-bank arbiter for the DSP
//            data memory. Address MSB selects the bank; different-bank
//            requests are served together, same-bank conflicts round-robin.
//            Reads return one cycle later, routed to the winning requester.
// Ports    : clk, rst                          - clock, async active-high reset
//            c_valid/c_ready/c_we/c_addr/c_wdata - core request channel
//            c_rvalid/c_rdata                  - core read response
//            s_*                               - sample-ingest port, same shape
//            b1_en/b1_we/b1_addr/b1_wdata/b1_rdata - bank 1 (address MSB = 0)
//            b2_*                              - bank 2 (address MSB = 1)
//            conflict_cnt                      - saturating same-bank conflicts
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mem_arbiter
  import dsp_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = C_MEM_ADDR_LEN,
  parameter int DATA_W = C_REG_WORD_LEN,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_valid,
  output logic              c_ready,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] s_rdata,
  output logic              b1_en,
  output logic              b1_we,
  output logic [ADDR_W-2:0] b1_addr,
  output logic [DATA_W-1:0] b1_wdata,
  input  logic [DATA_W-1:0] b1_rdata,
  output logic              b2_en,
  output logic              b2_we,
  output logic [ADDR_W-2:0] b2_addr,
  output logic [DATA_W-1:0] b2_wdata,
  input  logic [DATA_W-1:0] b2_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [1:0]        w_req       [2];
  logic [1:0]        w_gnt       [2];
  logic [1:0]        w_contested;
  logic              w_en        [2];
  logic              w_we        [2];
  logic [ADDR_W-2:0] w_addr      [2];
  logic [DATA_W-1:0] w_wdata     [2];

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam logic BANK_SEL = 1'(b);

      logic              w_sel_samp;
      logic [ADDR_W-2:0] w_addr_mux;
      logic [DATA_W-1:0] w_wdata_mux;
      logic [ADDR_W-2:0] r_addr_hold;
      logic [DATA_W-1:0] r_wdata_hold;

      assign w_req[b][C_ARB_CORE] = c_valid & (c_addr[ADDR_W-1] == BANK_SEL);
      assign w_req[b][C_ARB_SAMP] = s_valid & (s_addr[ADDR_W-1] == BANK_SEL);

      dsp_mem_rr_arb2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (w_req[b]),
        .gnt       (w_gnt[b]),
        .contested (w_contested[b])
      );

      assign w_sel_samp  = w_gnt[b][C_ARB_SAMP];
      assign w_en[b]     = |w_gnt[b];
      assign w_we[b]     = w_en[b] & (w_sel_samp ? s_we : c_we);
      assign w_addr_mux  = w_sel_samp ? s_addr[ADDR_W-2:0] : c_addr[ADDR_W-2:0];
      assign w_wdata_mux = w_sel_samp ? s_wdata : c_wdata;

      // Idle banks keep the last address/data so the bank pins do not toggle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_addr_hold  <= '0;
          r_wdata_hold <= '0;
        end else if (w_en[b]) begin
          r_addr_hold  <= w_addr_mux;
          r_wdata_hold <= w_wdata_mux;
        end
      end

      assign w_addr[b]  = w_en[b] ? w_addr_mux  : r_addr_hold;
      assign w_wdata[b] = w_en[b] ? w_wdata_mux : r_wdata_hold;
    end
  endgenerate

  assign b1_en    = w_en[C_BANK1];
  assign b1_we    = w_we[C_BANK1];
  assign b1_addr  = w_addr[C_BANK1];
  assign b1_wdata = w_wdata[C_BANK1];
  assign b2_en    = w_en[C_BANK2];
  assign b2_we    = w_we[C_BANK2];
  assign b2_addr  = w_addr[C_BANK2];
  assign b2_wdata = w_wdata[C_BANK2];

  // Grants are already qualified by valid and reset inside the arbiters.
  assign c_ready = w_gnt[C_BANK1][C_ARB_CORE] | w_gnt[C_BANK2][C_ARB_CORE];
  assign s_ready = w_gnt[C_BANK1][C_ARB_SAMP] | w_gnt[C_BANK2][C_ARB_SAMP];

  // Response routing: remember which bank each granted read went to so the
  // bank's registered read data can be steered back one cycle later.
  logic r_c_rvalid;
  logic r_c_bank;
  logic r_s_rvalid;
  logic r_s_bank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_rvalid <= 1'b0;
      r_c_bank   <= C_BANK1;
      r_s_rvalid <= 1'b0;
      r_s_bank   <= C_BANK1;
    end else begin
      r_c_rvalid <= c_ready & ~c_we;
      r_c_bank   <= c_addr[ADDR_W-1];
      r_s_rvalid <= s_ready & ~s_we;
      r_s_bank   <= s_addr[ADDR_W-1];
    end
  end

  assign c_rvalid = r_c_rvalid;
  assign s_rvalid = r_s_rvalid;
  assign c_rdata  = !r_c_rvalid ? '0 : (r_c_bank == C_BANK2) ? b2_rdata : b1_rdata;
  assign s_rdata  = !r_s_rvalid ? '0 : (r_s_bank == C_BANK2) ? b2_rdata : b1_rdata;

  // One increment per conflicting cycle, whichever bank(s) saw it.
  logic [CNT_W-1:0] r_conflict_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if ((|w_contested) && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign conflict_cnt = r_conflict_cnt;

endmodule : dsp_mem_arbiter
`default_nettype wire

// File: tb/tb_dsp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mem_arbiter
// Purpose  : Self-checking bench for dsp_mem_arbiter with behavioural
//            synchronous bank memories and a read-response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CW = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          c_valid, c_ready, c_we, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          s_valid, s_ready, s_we, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          b1_en, b1_we, b2_en, b2_we;
  logic [AW-2:0] b1_addr, b2_addr;
  logic [DW-1:0] b1_wdata, b1_rdata, b2_wdata, b2_rdata;
  logic [CW-1:0] conflict_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int exp_cnt     = 0;

  exp_t q_c[$];
  exp_t q_s[$];
  exp_t e_c, e_s;

  logic [DW-1:0] mem1 [128];
  logic [DW-1:0] mem2 [128];
  logic [DW-1:0] ref1 [128];
  logic [DW-1:0] ref2 [128];

  dsp_mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .c_valid      (c_valid),
    .c_ready      (c_ready),
    .c_we         (c_we),
    .c_addr       (c_addr),
    .c_wdata      (c_wdata),
    .c_rvalid     (c_rvalid),
    .c_rdata      (c_rdata),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_we         (s_we),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_rvalid     (s_rvalid),
    .s_rdata      (s_rdata),
    .b1_en        (b1_en),
    .b1_we        (b1_we),
    .b1_addr      (b1_addr),
    .b1_wdata     (b1_wdata),
    .b1_rdata     (b1_rdata),
    .b2_en        (b2_en),
    .b2_we        (b2_we),
    .b2_addr      (b2_addr),
    .b2_wdata     (b2_wdata),
    .b2_rdata     (b2_rdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous bank memories: read data registered the cycle after en.
  always @(posedge clk) begin
    if (b1_en) begin
      if (b1_we) mem1[b1_addr] <= b1_wdata;
      b1_rdata <= mem1[b1_addr];
    end
    if (b2_en) begin
      if (b2_we) mem2[b2_addr] <= b2_wdata;
      b2_rdata <= mem2[b2_addr];
    end
  end

  // Response scoreboard: every rvalid must match the oldest expectation,
  // both in data and in the cycle it was due.
  always @(negedge clk) begin
    vectors++;
    if (c_rvalid) begin
      if (q_c.size() == 0) begin
        miscompares++;
        $display("FAIL core_resp: got rvalid=1 rdata=%h at cycle %0d, required no response", c_rdata, cyc);
      end else begin
        e_c = q_c.pop_front();
        if (e_c.cyc !== cyc || c_rdata !== e_c.data) begin
          miscompares++;
          $display("FAIL core_resp: got rdata=%h at cycle %0d, required %h at cycle %0d", c_rdata, cyc, e_c.data, e_c.cyc);
        end
      end
    end else if (q_c.size() != 0 && q_c[0].cyc <= cyc) begin
      e_c = q_c.pop_front();
      miscompares++;
      $display("FAIL core_resp: got rvalid=0 at cycle %0d, required rdata=%h", cyc, e_c.data);
    end else if (c_rdata !== '0) begin
      miscompares++;
      $display("FAIL core_rdata_idle: got %h, required 0", c_rdata);
    end

    vectors++;
    if (s_rvalid) begin
      if (q_s.size() == 0) begin
        miscompares++;
        $display("FAIL samp_resp: got rvalid=1 rdata=%h at cycle %0d, required no response", s_rdata, cyc);
      end else begin
        e_s = q_s.pop_front();
        if (e_s.cyc !== cyc || s_rdata !== e_s.data) begin
          miscompares++;
          $display("FAIL samp_resp: got rdata=%h at cycle %0d, required %h at cycle %0d", s_rdata, cyc, e_s.data, e_s.cyc);
        end
      end
    end else if (q_s.size() != 0 && q_s[0].cyc <= cyc) begin
      e_s = q_s.pop_front();
      miscompares++;
      $display("FAIL samp_resp: got rvalid=0 at cycle %0d, required rdata=%h", cyc, e_s.data);
    end else if (s_rdata !== '0) begin
      miscompares++;
      $display("FAIL samp_rdata_idle: got %h, required 0", s_rdata);
    end
  end

  task automatic idle();
    c_valid = 1'b0; c_we = 1'b0;
    s_valid = 1'b0; s_we = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v == 15) ? 15 : v + 1;
  endfunction

  task automatic test_reset();
    c_valid = 1'b1; c_addr = 8'h05;
    s_valid = 1'b1; s_addr = 8'h85;
    @(negedge clk);
    vectors++;
    if ({c_ready, s_ready, b1_en, b2_en, b1_we, b2_we, c_rvalid, s_rvalid} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, required 00000000",
               {c_ready, s_ready, b1_en, b2_en, b1_we, b2_we, c_rvalid, s_rvalid});
    end
    vectors++;
    if (conflict_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d, required 0", conflict_cnt);
    end
    idle();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({c_ready, s_ready, b1_en, b2_en, b1_we, b2_we, c_rvalid, s_rvalid} !== 8'h00) begin
      miscompares++;
      $display("FAIL idle_ctrl: got %b, required 00000000",
               {c_ready, s_ready, b1_en, b2_en, b1_we, b2_we, c_rvalid, s_rvalid});
    end
    step();
    c_valid = 1'b1; c_we = 1'b0; c_addr = 8'h05;
    @(negedge clk);
    vectors++;
    if ({c_ready, b1_en, b1_we, s_ready, b2_en} !== 5'b11000 || b1_addr !== 7'h05) begin
      miscompares++;
      $display("FAIL first_read: got rdy/en/we/srdy/b2en=%b addr=%h, required 11000 addr=05",
               {c_ready, b1_en, b1_we, s_ready, b2_en}, b1_addr);
    end
    q_c.push_back('{ref1[5], cyc + 1});
    step();
    idle();
    step();
  endtask

  task automatic test_diff_banks();
    c_valid = 1'b1; c_we = 1'b0; c_addr = 8'h10;
    s_valid = 1'b1; s_we = 1'b1; s_addr = 8'h90; s_wdata = 16'h1234;
    @(negedge clk);
    vectors++;
    if ({c_ready, s_ready, b1_en, b1_we, b2_en, b2_we} !== 6'b111011 ||
        b1_addr !== 7'h10 || b2_addr !== 7'h10 || b2_wdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL diff_banks: got ctrl=%b b1a=%h b2a=%h b2d=%h, required 111011 10 10 1234",
               {c_ready, s_ready, b1_en, b1_we, b2_en, b2_we}, b1_addr, b2_addr, b2_wdata);
    end
    vectors++;
    if (conflict_cnt !== 4'(exp_cnt)) begin
      miscompares++;
      $display("FAIL diff_banks_cnt: got %0d, required %0d", conflict_cnt, exp_cnt);
    end
    q_c.push_back('{ref1[16], cyc + 1});
    ref2[16] = 16'h1234;
    step();
    idle();
    @(negedge clk);
    vectors++;
    if (b2_en !== 1'b0 || b2_we !== 1'b0 || b2_addr !== 7'h10) begin
      miscompares++;
      $display("FAIL bank_idle_hold: got en=%b we=%b addr=%h, required 0 0 10", b2_en, b2_we, b2_addr);
    end
    step();
  endtask

  task automatic test_contested(input logic bank, input int n);
    logic core_wins;
    logic [6:0] a_c, a_s;
    a_c = 7'h01; a_s = 7'h02;
    c_valid = 1'b1; c_we = 1'b0; c_addr = {bank, a_c};
    s_valid = 1'b1; s_we = 1'b0; s_addr = {bank, a_s};
    for (int i = 0; i < n; i++) begin
      core_wins = (i % 2 == 0);
      @(negedge clk);
      vectors++;
      if (c_ready !== core_wins || s_ready !== !core_wins ||
          (bank ? b2_en : b1_en) !== 1'b1 ||
          (bank ? b2_addr : b1_addr) !== (core_wins ? a_c : a_s)) begin
        miscompares++;
        $display("FAIL contested bank%0d cyc%0d: got crdy=%b srdy=%b addr=%h, required crdy=%b addr=%h",
                 bank + 1, i, c_ready, s_ready, bank ? b2_addr : b1_addr, core_wins,
                 core_wins ? a_c : a_s);
      end
      if (core_wins) q_c.push_back('{bank ? ref2[a_c] : ref1[a_c], cyc + 1});
      else           q_s.push_back('{bank ? ref2[a_s] : ref1[a_s], cyc + 1});
      step();
      exp_cnt = sat_inc(exp_cnt);
      vectors++;
      if (conflict_cnt !== 4'(exp_cnt)) begin
        miscompares++;
        $display("FAIL conflict_cnt cyc%0d: got %0d, required %0d", i, conflict_cnt, exp_cnt);
      end
    end
    idle();
    step();
  endtask

  task automatic test_reset_midop();
    c_valid = 1'b1; c_we = 1'b0; c_addr = 8'h03;
    s_valid = 1'b1; s_we = 1'b0; s_addr = 8'h04;
    @(negedge clk);
    vectors++;
    if (c_ready !== 1'b1 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_contest: got crdy=%b srdy=%b, required 1 0", c_ready, s_ready);
    end
    q_c.push_back('{ref1[3], cyc + 1});
    step();
    exp_cnt = sat_inc(exp_cnt);
    s_valid = 1'b0;
    c_addr  = 8'h07;
    @(negedge clk);
    vectors++;
    if (c_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_grant: got crdy=%b, required 1", c_ready);
    end
    c_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (conflict_cnt !== 4'd0 || c_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got cnt=%0d crdy=%b, required 0 0", conflict_cnt, c_ready);
    end
    #1 rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    vectors++;
    if (c_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL dropped_resp: got c_rvalid=%b, required 0", c_rvalid);
    end
    step();
    c_valid = 1'b1; c_addr = 8'h03;
    s_valid = 1'b1; s_addr = 8'h04;
    @(negedge clk);
    vectors++;
    if (c_ready !== 1'b1 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_rr: got crdy=%b srdy=%b, required 1 0", c_ready, s_ready);
    end
    q_c.push_back('{ref1[3], cyc + 1});
    step();
    exp_cnt = sat_inc(exp_cnt);
    vectors++;
    if (conflict_cnt !== 4'(exp_cnt)) begin
      miscompares++;
      $display("FAIL post_reset_cnt: got %0d, required %0d", conflict_cnt, exp_cnt);
    end
    idle();
    step();
  endtask

  task automatic test_write_then_read();
    c_valid = 1'b1; c_we = 1'b0; c_addr = 8'h0A;
    s_valid = 1'b1; s_we = 1'b1; s_addr = 8'h0A; s_wdata = 16'hBEEF;
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b1 || c_ready !== 1'b0 || b1_we !== 1'b1 ||
        b1_addr !== 7'h0A || b1_wdata !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL wr_first: got srdy=%b crdy=%b we=%b addr=%h data=%h, required 1 0 1 0a beef",
               s_ready, c_ready, b1_we, b1_addr, b1_wdata);
    end
    ref1[10] = 16'hBEEF;
    step();
    exp_cnt = sat_inc(exp_cnt);
    s_valid = 1'b0; s_we = 1'b0;
    @(negedge clk);
    vectors++;
    if (c_ready !== 1'b1 || b1_we !== 1'b0 || b1_addr !== 7'h0A) begin
      miscompares++;
      $display("FAIL rd_second: got crdy=%b we=%b addr=%h, required 1 0 0a", c_ready, b1_we, b1_addr);
    end
    q_c.push_back('{ref1[10], cyc + 1});
    step();
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      c_valid = 1'b1; c_we = 1'b0; c_addr = 8'(8'h20 + i);
      s_valid = 1'b1; s_we = 1'b0; s_addr = 8'(8'hA0 + i);
      @(negedge clk);
      vectors++;
      if (c_ready !== 1'b1 || s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d: got crdy=%b srdy=%b, required 1 1", i, c_ready, s_ready);
      end
      q_c.push_back('{ref1[8'h20 + i], cyc + 1});
      q_s.push_back('{ref2[8'h20 + i], cyc + 1});
      step();
    end
    idle();
    step();
    vectors++;
    if (conflict_cnt !== 4'(exp_cnt)) begin
      miscompares++;
      $display("FAIL b2b_cnt: got %0d, required %0d", conflict_cnt, exp_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem1[i] = 16'(16'h1000 + i);
      mem2[i] = 16'(16'h2000 + i);
      ref1[i] = 16'(16'h1000 + i);
      ref2[i] = 16'(16'h2000 + i);
    end
    b1_rdata = '0; b2_rdata = '0;
    rst = 1'b1;
    c_addr = '0; c_wdata = '0; s_addr = '0; s_wdata = '0;
    idle();

    test_reset();
    test_diff_banks();
    test_contested(1'b0, 4);
    test_contested(1'b1, 20);
    test_reset_midop();
    test_write_then_read();
    test_back_to_back();

    step();
    step();
    vectors++;
    if (q_c.size() != 0 || q_s.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d core / %0d sample pending, required 0 0", q_c.size(), q_s.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dsp_mem_arbiter
`default_nettype wire
